// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter unit.
// With PC_UNIT_RVC_EN defined, the alignment check is relaxed to 2 bytes.
package pc_unit_pkg;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        SEQ,
        BR,
        JALR,
        TRAP,
        MRET,
        HOLD
    } pc_sel_t;

    localparam int INC_WORD = 4;
    localparam int INC_HALF = 2;

`ifdef PC_UNIT_RVC_EN
    localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
    localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

    // A redirect target is illegal when any bit below the alignment boundary is set.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |(low_bits & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
// Holds the PC and the saved exception PC inside pc_unit.
module pc_reg
    import pc_unit_pkg::*;
#(
    parameter int              WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: RUN/HALT control, prioritised next-PC select, trap/mret with saved EPC.
// Define PC_UNIT_RVC_EN to add is_compressed (2-byte step) and relax alignment to 2 bytes.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jalr_en,
    input  logic [WIDTH-1:0] jalr_target,
    input  logic             trap_req,
    input  logic             mret_req,
    input  logic             halt_req,
    input  logic             resume,
`ifdef PC_UNIT_RVC_EN
    input  logic             is_compressed,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic             misaligned,
    output logic             redirect,
    output logic             halted
);

    state_t           state;
    state_t           state_next;
    pc_sel_t          sel;
    logic             mis_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] jalr_clean;

`ifdef PC_UNIT_RVC_EN
    assign inc = is_compressed ? WIDTH'(INC_HALF) : WIDTH'(INC_WORD);
`else
    assign inc = WIDTH'(INC_WORD);
`endif

    assign pc_plus    = pc + inc;
    assign jalr_clean = {jalr_target[WIDTH-1:1], 1'b0};
    assign halted     = (state == HALT);

    // A misaligned redirect is turned into a trap here, so it shares the TRAP select.
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        sel        = HOLD;
        mis_next   = 1'b0;
        unique case (state)
            RUN: begin
                if (trap_req) begin
                    sel = TRAP;
                end else begin
                    if (halt_req) begin
                        state_next = HALT;
                    end
                    if (halt_req || stall) begin
                        sel = HOLD;
                    end else if (mret_req) begin
                        sel = MRET;
                    end else if (jalr_en) begin
                        if (is_misaligned(jalr_clean[1:0])) begin
                            sel      = TRAP;
                            mis_next = 1'b1;
                        end else begin
                            sel = JALR;
                        end
                    end else if (branch_taken) begin
                        if (is_misaligned(branch_target[1:0])) begin
                            sel      = TRAP;
                            mis_next = 1'b1;
                        end else begin
                            sel = BR;
                        end
                    end else begin
                        sel = SEQ;
                    end
                end
            end
            HALT: begin
                if (resume && !halt_req) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        pc_next = pc;
        unique case (sel)
            SEQ:     pc_next = pc_plus;
            BR:      pc_next = branch_target;
            JALR:    pc_next = jalr_clean;
            TRAP:    pc_next = TRAP_VECTOR;
            MRET:    pc_next = epc;
            HOLD:    pc_next = pc;
            default: pc_next = pc;
        endcase
    end

    pc_reg #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VECTOR)
    ) u_pc_reg (
        .clk  (clk),
        .reset(reset),
        .load (sel != HOLD),
        .d    (pc_next),
        .q    (pc)
    );

    pc_reg #(
        .WIDTH      (WIDTH),
        .RESET_VALUE('0)
    ) u_epc_reg (
        .clk  (clk),
        .reset(reset),
        .load (sel == TRAP),
        .d    (pc),
        .q    (epc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            misaligned <= 1'b0;
            redirect   <= 1'b0;
        end else begin
            state      <= state_next;
            misaligned <= mis_next;
            redirect   <= (sel == TRAP) || (sel == MRET) || (sel == JALR) || (sel == BR);
        end
    end

endmodule
